// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS pipeline stages.
package cpu_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    CNT_FETCH = 2'd0,
    CNT_STALL = 2'd1,
    CNT_FLUSH = 2'd2
  } cnt_e;

  localparam int NUM_CNT = 3;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  // Redirect targets are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk_i) begin
    if (rst_i)                      cnt_o <= '0;
    else if (inc_i && cnt_o != '1)  cnt_o <= cnt_o + W'(1);
  end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID register, event counters.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pc_write_i,
  input  logic             if_id_write_i,
  input  logic             flush_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  branch_target_i,
  input  logic             jump_i,
  input  logic [XLEN-1:0]  jump_target_i,
  input  logic [XLEN-1:0]  imem_instr_i,
  output logic [XLEN-1:0]  imem_addr_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  if_id_pc4_o,
  output logic [XLEN-1:0]  if_id_instr_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] pc_next;
  if_id_t          if_id;

  assign pc4 = pc + PC_INC;

  // Jump outranks branch when ID resolves both in the same cycle.
  always_comb begin
    pc_next = pc4;
    if (jump_i)              pc_next = word_align(jump_target_i);
    else if (branch_taken_i) pc_next = word_align(branch_target_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                      pc <= RESET_PC;
    else if (start_i && pc_write_i) pc <= pc_next;
  end

  // Flush wins over a held IF/ID so a squashed slot never survives a stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_id <= '{pc4: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (start_i) begin
      if (flush_i)            if_id <= '{pc4: pc4, instr: NOP_INSTR, valid: 1'b0};
      else if (if_id_write_i) if_id <= '{pc4: pc4, instr: imem_instr_i, valid: 1'b1};
    end
  end

  logic [NUM_CNT-1:0]            cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt;

  assign cnt_inc[CNT_FETCH] = start_i && !flush_i &&  if_id_write_i;
  assign cnt_inc[CNT_STALL] = start_i && !flush_i && !if_id_write_i;
  assign cnt_inc[CNT_FLUSH] = start_i &&  flush_i;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (cnt_inc[i]),
      .cnt_o (cnt[i])
    );
  end

  assign imem_addr_o   = pc;
  assign pc_o          = pc;
  assign if_id_pc4_o   = if_id.pc4;
  assign if_id_instr_o = if_id.instr;
  assign if_id_valid_o = if_id.valid;
  assign fetch_cnt_o   = cnt[CNT_FETCH];
  assign stall_cnt_o   = cnt[CNT_STALL];
  assign flush_cnt_o   = cnt[CNT_FLUSH];
endmodule

// File: tb/tb_if_stage.sv
// Randomized + directed bench for if_stage against a behavioural fetch model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, start, pcw, ifw, flush, br, jmp;
  logic [31:0] bt, jt;
  logic [31:0] addr_a, addr_b, instr_a, instr_b;
  logic [31:0] pc_a, pc4_a, ins_a, pc_b, pc4_b, ins_b;
  logic        vld_a, vld_b;
  logic [15:0] fc_a, sc_a, xc_a;
  logic [1:0]  fc_b, sc_b, xc_b;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  assign instr_a = mem(addr_a);
  assign instr_b = mem(addr_b);

  if_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_write_i(pcw), .if_id_write_i(ifw),
    .flush_i(flush), .branch_taken_i(br), .branch_target_i(bt), .jump_i(jmp),
    .jump_target_i(jt), .imem_instr_i(instr_a), .imem_addr_o(addr_a), .pc_o(pc_a),
    .if_id_pc4_o(pc4_a), .if_id_instr_o(ins_a), .if_id_valid_o(vld_a),
    .fetch_cnt_o(fc_a), .stall_cnt_o(sc_a), .flush_cnt_o(xc_a));

  if_stage #(.RESET_PC(32'h0), .CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pc_write_i(pcw), .if_id_write_i(ifw),
    .flush_i(flush), .branch_taken_i(br), .branch_target_i(bt), .jump_i(jmp),
    .jump_target_i(jt), .imem_instr_i(instr_b), .imem_addr_o(addr_b), .pc_o(pc_b),
    .if_id_pc4_o(pc4_b), .if_id_instr_o(ins_b), .if_id_valid_o(vld_b),
    .fetch_cnt_o(fc_b), .stall_cnt_o(sc_b), .flush_cnt_o(xc_b));

  int n_chk = 0, n_fail = 0;

  // Model: architectural view of the stage; counters kept as unbounded event tallies.
  logic [31:0] m_pc, m_pc4, m_ins;
  logic        m_vld;
  int          m_fetch, m_stall, m_flush;

  function automatic longint sat(input int cnt, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (cnt > mx) ? mx : cnt;
  endfunction

  task automatic cmp(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    cmp("pc", pc_a, m_pc);
    cmp("imem_addr", addr_a, m_pc);
    cmp("if_id_pc4", pc4_a, m_pc4);
    cmp("if_id_instr", ins_a, m_ins);
    cmp("if_id_valid", vld_a, m_vld);
    cmp("fetch_cnt", fc_a, sat(m_fetch, 16));
    cmp("stall_cnt", sc_a, sat(m_stall, 16));
    cmp("flush_cnt", xc_a, sat(m_flush, 16));
    cmp("pc_small", pc_b, m_pc);
    cmp("fetch_cnt_small", fc_b, sat(m_fetch, 2));
    cmp("stall_cnt_small", sc_b, sat(m_stall, 2));
    cmp("flush_cnt_small", xc_b, sat(m_flush, 2));
  endtask

  task automatic model_edge();
    logic [31:0] cur = m_pc;
    if (rst) begin
      m_pc = 32'h0; m_pc4 = 0; m_ins = 0; m_vld = 0;
      m_fetch = 0; m_stall = 0; m_flush = 0;
    end else if (start) begin
      if (pcw) m_pc = jmp ? (jt & ~32'd3) : br ? (bt & ~32'd3) : cur + 32'd4;
      if (flush) begin
        m_pc4 = cur + 32'd4; m_ins = 0; m_vld = 0; m_flush++;
      end else if (ifw) begin
        m_pc4 = cur + 32'd4; m_ins = mem(cur); m_vld = 1; m_fetch++;
      end else begin
        m_stall++;
      end
    end
  endtask

  // Apply one cycle of inputs, advance model and DUT, then compare off-edge.
  task automatic step(input logic r, input logic s, input logic pw, input logic iw,
                      input logic fl, input logic b, input logic [31:0] btg,
                      input logic j, input logic [31:0] jtg);
    rst = r; start = s; pcw = pw; ifw = iw; flush = fl; br = b; bt = btg; jmp = j; jt = jtg;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_pc = 32'hx;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("reset_pc_lit", pc_a, 32'h0);
    cmp("reset_valid_lit", vld_a, 0);
    cmp("reset_instr_lit", ins_a, 32'h0);

    run(4);
    cmp("seq_pc_lit", pc_a, 32'd16);
    cmp("seq_pc4_lit", pc4_a, 32'd16);
    cmp("seq_fetch_lit", fc_a, 4);
    cmp("seq_stall_lit", sc_a, 0);

    step(1, 1, 1, 1, 0, 0, 0, 0, 0);
    run(2);
    stall(2);
    cmp("stall_pc_lit", pc_a, 32'd8);
    cmp("stall_instr_lit", ins_a, mem(32'd4));
    cmp("stall_cnt_lit", sc_a, 2);
    run(1);
    cmp("resume_pc_lit", pc_a, 32'd12);

    step(0, 1, 1, 1, 1, 1, 32'h40, 0, 0);
    cmp("br_pc_lit", pc_a, 32'h40);
    cmp("br_valid_lit", vld_a, 0);
    cmp("br_flush_lit", xc_a, 1);
    run(1);
    cmp("br_tgt_instr_lit", ins_a, mem(32'h40));
    cmp("br_tgt_valid_lit", vld_a, 1);

    step(0, 1, 1, 1, 1, 1, 32'h40, 1, 32'h80);
    cmp("jb_pc_lit", pc_a, 32'h80);
    cmp("jb_flush_lit", xc_a, 2);
    step(0, 1, 1, 1, 1, 0, 0, 1, 32'h83);
    cmp("align_pc_lit", pc_a, 32'h80);

    for (int i = 0; i < 3; i++)
      step(0, 0, $urandom_range(1), $urandom_range(1), $urandom_range(1),
           $urandom_range(1), $urandom, $urandom_range(1), $urandom);
    cmp("frozen_pc_lit", pc_a, 32'h80);
    cmp("frozen_flush_lit", xc_a, 3);
    step(0, 1, 1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cmp("wrap_pre_lit", pc_a, 32'hFFFF_FFFC);
    run(1);
    cmp("wrap_pc_lit", pc_a, 32'h0);
    cmp("wrap_pc4_lit", pc4_a, 32'h0);

    step(1, 1, 1, 1, 0, 0, 0, 0, 0);
    stall(5);
    cmp("sat_small_lit", sc_b, 3);
    cmp("sat_big_lit", sc_a, 5);
    step(1, 1, 0, 0, 1, 0, 0, 0, 0);
    cmp("rst_stall_lit", sc_b, 0);
    cmp("rst_flush_lit", xc_a, 0);
    cmp("rst_pc_lit", pc_a, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic r, s, pw, iw, fl, b, j;
      r  = ($urandom_range(199) == 0);
      s  = ($urandom_range(7) != 0);
      pw = ($urandom_range(4) != 0);
      iw = pw ? ($urandom_range(9) != 0) : ($urandom_range(3) == 0);
      b  = ($urandom_range(5) == 0);
      j  = ($urandom_range(7) == 0);
      fl = (b || j) ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
      step(r, s, pw, iw, fl, b, $urandom, j, (i % 97 == 0) ? 32'hFFFF_FFFC : $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, next-PC selection and the IF/ID pipeline register.
- Drives the instruction-memory address and captures the returned word with PC+4 into IF/ID for the decode stage.
- Honours stall (PC/IF-ID write enables) from hazard detection, and redirect/flush from branch and jump resolution in ID.
- Keeps saturating fetch/stall/flush event counters so benches read pipeline statistics directly instead of reconstructing them from internal signals.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of each event counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  0 = whole stage frozen (PC, IF/ID, counters hold).
- pc_write_i  in  1  from hazard detection; 0 = hold PC.
- if_id_write_i  in  1  from hazard detection; 0 = hold IF/ID.
- flush_i  in  1  squash the instruction currently being fetched.
- branch_taken_i  in  1  taken branch resolved in ID.
- branch_target_i  in  32  branch target address.
- jump_i  in  1  jump resolved in ID.
- jump_target_i  in  32  jump target address.
- imem_instr_i  in  32  instruction word at imem_addr_o (combinational memory).
- imem_addr_o  out  32  equals pc_o.
- pc_o  out  32  current PC.
- if_id_pc4_o  out  32  PC+4 of the instruction held in IF/ID.
- if_id_instr_o  out  32  instruction held in IF/ID.
- if_id_valid_o  out  1  1 = IF/ID holds a real (non-squashed) instruction.
- fetch_cnt_o  out  CNT_W  valid fetches into IF/ID.
- stall_cnt_o  out  CNT_W  IF/ID hold cycles.
- flush_cnt_o  out  CNT_W  flush cycles.

Behaviour:
- Reset (rst_i=1 at a rising edge, regardless of start_i): pc_o=RESET_PC; if_id_pc4_o=0; if_id_instr_o=0 (NOP); if_id_valid_o=0; all counters=0.
- rst_i asserted mid-stall or mid-flush discards all pending state on that edge.
- Next-PC priority, evaluated each rising edge:
  1. start_i=0: hold.
  2. pc_write_i=0: hold. This overrides any redirect; hazard detection guarantees no redirect is lost.
  3. jump_i=1: jump_target_i.
  4. branch_taken_i=1: branch_target_i.
  5. Otherwise: pc_o+4.
- Next-PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). Bits [1:0] of any loaded target are forced to 0.
- IF/ID priority, evaluated each rising edge:
  1. start_i=0: hold.
  2. flush_i=1: instr=0, valid=0, pc4=pc_o+4. Flush beats if_id_write_i=0.
  3. if_id_write_i=1: instr=imem_instr_i, pc4=pc_o+4, valid=1.
  4. Otherwise: hold.
- Latency: word at pc_o appears on if_id_instr_o one cycle later.
- A taken redirect costs exactly 1 bubble when ID asserts flush_i in the same cycle.
- Counters (all gated by start_i=1; each saturates at all-ones and never wraps):
  - fetch_cnt_o +1 when IF/ID loads with valid=1.
  - stall_cnt_o +1 when flush_i=0 and if_id_write_i=0.
  - flush_cnt_o +1 when flush_i=1.
- Simultaneous jump_i and branch_taken_i: jump wins. flush_cnt_o increments once.
- All outputs are registered except imem_addr_o, which is a wire from the PC register.

Decomposition:
- Shared package cpu_pkg: XLEN=32, NOP_INSTR=32'h0000_0000, PC_INC=4, default RESET_PC.
- One sub-module sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated three times.
- PC register and IF/ID register stay inline.

Test Plan:
- Reset then start_i=1 for 4 cycles, no hazards -> pc_o 0,4,8,12,16; if_id_pc4_o 4,8,12,16; fetch_cnt_o=4; stall/flush counts 0.
- pc_write_i=0 and if_id_write_i=0 for 2 cycles at pc_o=8 -> pc_o holds 8, IF/ID holds the word from 4, stall_cnt_o=2; resumes at 12 after release.
- branch_taken_i=1, branch_target_i=32'h40, flush_i=1 at pc_o=12 -> next pc_o=32'h40, if_id_valid_o=0, if_id_instr_o=0, flush_cnt_o=1; word at 32'h40 valid next cycle.
- jump_i=1 (target 32'h80) and branch_taken_i=1 (target 32'h40) together, with flush_i=1 -> pc_o=32'h80, flush_cnt_o +1 only once; target 32'h83 loads as 32'h80.
- start_i=0 for 3 cycles mid-run, and separately pc_o=32'hFFFF_FFFC -> all state frozen while start_i=0; the next increment gives pc_o=0.
- CNT_W=2 with 5 stall cycles, then rst_i=1 during a stall -> stall_cnt_o saturates at 3; after reset all counters=0 and pc_o=RESET_PC.
